// File: rtl/piso_tx_reg_pkg.sv
// Shared definitions for the serial transmit blocks: FSM encodings,
// default word width and counter sizing helper.
package piso_tx_reg_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_DONE  = 2'd2
    } tx_state_e;

    localparam int TX_DEFAULT_WIDTH = 8;

    // Counter must hold n-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_reg_dn_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module dn_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement, decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/piso_tx_reg.sv
// Parallel-in/serial-out transmit register: loads an n-bit word in IDLE and
// shifts it out MSB first, one bit per enabled clock, with valid/busy/done flags.
module piso_tx_reg
    import piso_tx_reg_pkg::*;
#(
    parameter int n = TX_DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [n-1:0] in,
    input  logic         ld,
    input  logic         en,
    output logic         sout,
    output logic         sout_v,
    output logic         busy,
    output logic         done
);

    localparam int CW = cnt_width(n);

    tx_state_e    state_q;
    tx_state_e    state_d;
    logic [n-1:0] sh_q;
    logic [n-1:0] sh_d;
    logic         sout_q;
    logic         sout_d;
    logic         sout_v_q;
    logic         sout_v_d;
    logic         busy_q;
    logic         busy_d;
    logic         done_q;
    logic         done_d;
    logic         cnt_ld_s;
    logic         cnt_dec_s;
    logic         cnt_zero_s;

    dn_counter #(
        .W (CW)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (clr),
        .load     (cnt_ld_s),
        .load_val (CW'(n - 1)),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Next state and shift register; the cnt==0 test is checked before any decrement.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_ld_s  = 1'b0;
        cnt_dec_s = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (ld) begin
                    sh_d     = in;
                    cnt_ld_s = 1'b1;
                    state_d  = TX_SHIFT;
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_SHIFT: begin
                if (en) begin
                    if (cnt_zero_s) begin
                        state_d = TX_DONE;
                    end else begin
                        sh_d      = {sh_q[n-2:0], 1'b0};
                        cnt_dec_s = 1'b1;
                    end
                end else begin
                    state_d = TX_SHIFT;
                end
            end
            TX_DONE: begin
                state_d = TX_IDLE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // Outputs are precomputed from next state so they leave flops directly.
    always_comb begin
        sout_d   = (state_d == TX_SHIFT) ? sh_d[n-1] : 1'b0;
        sout_v_d = (state_d == TX_SHIFT);
        busy_d   = (state_d != TX_IDLE);
        done_d   = (state_d == TX_DONE);
    end

    // FSM, shift register and registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= TX_IDLE;
            sh_q     <= {n{1'b0}};
            sout_q   <= 1'b0;
            sout_v_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            sout_q   <= sout_d;
            sout_v_q <= sout_v_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sout   = sout_q;
    assign sout_v = sout_v_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_piso_tx_reg.sv
// Bench for piso_tx_reg at n=2, 8 and 16 against an index-based bit model.
module tb_piso_tx_reg;

    logic        clk = 1'b0;
    logic        clr;
    logic        ld;
    logic        en;
    logic [15:0] in_w;
    int          sel;

    logic ld2, ld8, ld16;
    logic sout2, sout_v2, busy2, done2;
    logic sout8, sout_v8, busy8, done8;
    logic sout16, sout_v16, busy16, done16;
    logic sout_m, sout_v_m, busy_m, done_m;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ld2  = ld && (sel == 2);
    assign ld8  = ld && (sel == 8);
    assign ld16 = ld && (sel == 16);

    always_comb begin
        case (sel)
            2:       {sout_m, sout_v_m, busy_m, done_m} = {sout2, sout_v2, busy2, done2};
            16:      {sout_m, sout_v_m, busy_m, done_m} = {sout16, sout_v16, busy16, done16};
            default: {sout_m, sout_v_m, busy_m, done_m} = {sout8, sout_v8, busy8, done8};
        endcase
    end

    piso_tx_reg #(.n(2)) dut2 (
        .clk(clk), .clr(clr), .in(in_w[1:0]), .ld(ld2), .en(en),
        .sout(sout2), .sout_v(sout_v2), .busy(busy2), .done(done2)
    );
    piso_tx_reg #(.n(8)) dut8 (
        .clk(clk), .clr(clr), .in(in_w[7:0]), .ld(ld8), .en(en),
        .sout(sout8), .sout_v(sout_v8), .busy(busy8), .done(done8)
    );
    piso_tx_reg #(.n(16)) dut16 (
        .clk(clk), .clr(clr), .in(in_w), .ld(ld16), .en(en),
        .sout(sout16), .sout_v(sout_v16), .busy(busy16), .done(done16)
    );

    // One full transfer; caller must be between a negedge and the next posedge.
    // stall[c]=1 drops en during cycle c (cycle 1 = first bit cycle).
    task automatic run_xfer(input int w, input logic [15:0] word,
                            input logic [63:0] stall, input bit junk_ld);
        int idx;
        int cyc;
        logic [3:0] exp_v;
        sel  = w;
        in_w = word;
        ld   = 1'b1;
        en   = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        idx = 0;
        cyc = 1;
        while (idx < w && cyc < 100) begin
            en   = (cyc < 64) ? ~stall[cyc] : 1'b1;
            ld   = junk_ld;
            in_w = junk_ld ? 16'hFFFF : 16'($urandom);
            @(negedge clk);
            exp_v = {word[w-1-idx], 1'b1, 1'b1, 1'b0};
            n_cmp++;
            if ({sout_m, sout_v_m, busy_m, done_m} !== exp_v) begin
                n_err++;
                $display("FAIL shift n=%0d word=%h cyc=%0d bit=%0d: sout/v/busy/done got %b want %b",
                         w, word, cyc, idx, {sout_m, sout_v_m, busy_m, done_m}, exp_v);
            end
            @(posedge clk);
            if (en) idx++;
            #1;
            cyc++;
        end
        if (cyc >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout n=%0d: transfer exceeded cycle budget", w);
        end
        @(negedge clk);
        n_cmp++;
        if ({sout_m, sout_v_m, busy_m, done_m} !== 4'b0011) begin
            n_err++;
            $display("FAIL done_cycle n=%0d cyc=%0d: sout/v/busy/done got %b want 0011",
                     w, cyc, {sout_m, sout_v_m, busy_m, done_m});
        end
        @(posedge clk);
        #1;
        ld = 1'b0;
        en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({sout_m, sout_v_m, busy_m, done_m} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_after n=%0d: sout/v/busy/done got %b want 0000",
                     w, {sout_m, sout_v_m, busy_m, done_m});
        end
    endtask

    task automatic test_reset();
        sel  = 8;
        ld   = 1'b0;
        en   = 1'b0;
        in_w = 16'h0000;
        clr  = 1'b1;
        #2;
        clr = 1'b0;
        #1;
        n_cmp++;
        if ({sout8, sout_v8, busy8, done8, sout2, busy2, sout16, busy16} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_async: outputs got %b want 00000000",
                     {sout8, sout_v8, busy8, done8, sout2, busy2, sout16, busy16});
        end
        repeat (2) @(posedge clk);
        #2;
        clr = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({sout_m, sout_v_m, busy_m, done_m} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_release: got %b want 0000",
                         {sout_m, sout_v_m, busy_m, done_m});
            end
        end
    endtask

    task automatic test_basic();
        run_xfer(8, 16'h00A5, 64'h0, 1'b0);
        run_xfer(8, 16'h005A, 64'h0, 1'b0);
    endtask

    task automatic test_stall();
        run_xfer(8, 16'h00C3, 64'h38, 1'b0);
    endtask

    task automatic test_ignored_load();
        run_xfer(8, 16'h0096, 64'h0, 1'b1);
        run_xfer(8, 16'h0041, 64'h0, 1'b0);
    endtask

    task automatic test_abort();
        sel  = 8;
        in_w = 16'h003C;
        ld   = 1'b1;
        en   = 1'b1;
        @(posedge clk);
        #1;
        ld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        n_cmp++;
        if ({sout_m, sout_v_m, busy_m, done_m} !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_async: got %b want 0000", {sout_m, sout_v_m, busy_m, done_m});
        end
        repeat (2) @(posedge clk);
        #2;
        clr = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if ({sout_m, sout_v_m, busy_m, done_m} !== 4'b0000) begin
                n_err++;
                $display("FAIL abort_no_done: got %b want 0000", {sout_m, sout_v_m, busy_m, done_m});
            end
        end
        run_xfer(8, 16'h0001, 64'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_xfer(8, 16'h00F0, 64'h0, 1'b0);
        run_xfer(8, 16'h000F, 64'h0, 1'b0);
        run_xfer(8, 16'h0081, 64'h0, 1'b0);
    endtask

    task automatic test_width_sweep();
        run_xfer(2, 16'h0002, 64'h0, 1'b0);
        run_xfer(2, 16'h0001, 64'h0, 1'b0);
        run_xfer(16, 16'hAAAA, 64'h0, 1'b0);
        run_xfer(16, 16'h5555, 64'h0, 1'b0);
    endtask

    task automatic test_random();
        int w;
        logic [63:0] st;
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 2))
                0:       w = 2;
                1:       w = 8;
                default: w = 16;
            endcase
            st = {$urandom, $urandom} & {$urandom, $urandom};
            run_xfer(w, 16'($urandom), st, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ignored_load();
        test_abort();
        test_back_to_back();
        test_width_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
